// File: rtl/ycbcr444_to_422_packer.sv
// ycbcr444_to_422_packer: 4:4:4 to interleaved 4:2:2 YCbCr packer with aligned sync/DE and line-length monitoring.
module ycbcr444_to_422_packer #(
  parameter bit         FILTER_EN = 1'b1,
  parameter bit         CB_FIRST  = 1'b1,
  parameter logic [7:0] BLANK_Y   = 8'h10,
  parameter logic [7:0] BLANK_C   = 8'h80
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        in_de,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic [7:0]  in_y,
  input  logic [7:0]  in_cb,
  input  logic [7:0]  in_cr,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic [7:0]  out_y,
  output logic [7:0]  out_cb_cr,
  output logic [23:0] out_data_hdmi,
  output logic [11:0] line_len,
  output logic        odd_line_err
);
  logic        de1_q, hs1_q, vs1_q, ph1_q, de2_q, hs2_q, vs2_q, ph2_q;
  logic        err_q, err_d, skip_q, fall;
  logic [7:0]  y1_q, ce1_q, co1_q, y2_q, ce2_q, co2_q, hold_q, chroma;
  logic [11:0] cnt_q, cnt_d, len_q, len_d;

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  // ce carries the even-pixel chroma role, co the odd-pixel role
  always_comb begin
    fall   = de1_q & ~in_de;
    cnt_d  = fall ? 12'd0 : (in_de && cnt_q != 12'hfff) ? cnt_q + 12'd1 : cnt_q;
    len_d  = (fall & ~skip_q) ? cnt_q : len_q;
    err_d  = (fall & ~skip_q & cnt_q[0]) | (err_q & ~(in_vsync & ~vs1_q));
    chroma = ph2_q ? (FILTER_EN ? avg(hold_q, co2_q) : hold_q)
                   : ((FILTER_EN && de1_q) ? avg(ce2_q, ce1_q) : ce2_q);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      {de1_q, hs1_q, vs1_q, ph1_q, de2_q, hs2_q, vs2_q, ph2_q} <= '0;
      {y1_q, ce1_q, co1_q, y2_q, ce2_q, co2_q, hold_q} <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
      skip_q <= 1'b1;
    end else begin
      de1_q  <= in_de;
      hs1_q  <= in_hsync;
      vs1_q  <= in_vsync;
      y1_q   <= in_y;
      ce1_q  <= CB_FIRST ? in_cb : in_cr;
      co1_q  <= CB_FIRST ? in_cr : in_cb;
      ph1_q  <= de1_q & ~ph1_q;
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      y2_q   <= y1_q;
      ce2_q  <= ce1_q;
      co2_q  <= co1_q;
      ph2_q  <= ph1_q;
      hold_q <= (de2_q & ~ph2_q) ? co2_q : hold_q;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      err_q  <= err_d;
      skip_q <= skip_q & in_de;
    end
  end

  assign out_de        = de2_q;
  assign out_hsync     = hs2_q;
  assign out_vsync     = vs2_q;
  assign out_y         = de2_q ? y2_q : BLANK_Y;
  assign out_cb_cr     = de2_q ? chroma : BLANK_C;
  assign out_data_hdmi = {out_cb_cr, out_y, 8'h00};
  assign line_len      = len_q;
  assign odd_line_err  = err_q;
endmodule
